// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, queued in an output FIFO.
// Latency: one cycle from accept to FIFO head; there is no combinational input-to-output path.
// Backpressure: in_ready = !full, with no combinational dependence on a same-cycle pop.
// Optional: define ENCODER_RANGE_CHK_EN to flag immediates that do not fit their format.
module rv32i_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       op,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic [9:0]       func,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [32:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [31:0]      r_last_instr;
  logic             r_last_err;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [31:0] w_instr;
  logic        w_err;
  logic        w_push;
  logic        w_pop;
  logic [32:0] w_head;
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;

  assign w_f7 = func[9:3];
  assign w_f3 = func[2:0];

  // Combinational field packing; unknown opcodes produce a zero word with err set
  always_comb begin
    w_instr = 32'd0;
    w_err   = 1'b0;
    case (op)
      7'b0110011: w_instr = {w_f7, rs2, rs1, w_f3, rd, op};
      7'b0010011: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_instr = {w_f7, imm[4:0], rs1, w_f3, rd, op};
`ifdef ENCODER_RANGE_CHK_EN
          w_err = (imm[31:5] != 27'd0);
`endif
        end else begin
          w_instr = {imm[11:0], rs1, w_f3, rd, op};
`ifdef ENCODER_RANGE_CHK_EN
          w_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
        end
      end
      7'b0000011, 7'b1100111: begin
        w_instr = {imm[11:0], rs1, w_f3, rd, op};
`ifdef ENCODER_RANGE_CHK_EN
        w_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
      end
      7'b0100011: begin
        w_instr = {imm[11:5], rs2, rs1, w_f3, imm[4:0], op};
`ifdef ENCODER_RANGE_CHK_EN
        w_err = !((&imm[31:11]) || !(|imm[31:11]));
`endif
      end
      7'b1100011: begin
        w_instr = {imm[12], imm[10:5], rs2, rs1, w_f3, imm[4:1], imm[11], op};
`ifdef ENCODER_RANGE_CHK_EN
        w_err = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
`endif
      end
      7'b0110111, 7'b0010111: begin
        w_instr = {imm[31:12], rd, op};
`ifdef ENCODER_RANGE_CHK_EN
        w_err = (imm[11:0] != 12'd0);
`endif
      end
      7'b1101111: begin
        w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
`ifdef ENCODER_RANGE_CHK_EN
        w_err = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
`endif
      end
      default: begin
        w_instr = 32'd0;
        w_err   = 1'b1;
      end
    endcase
  end

  assign in_ready  = (r_count != L_FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // When empty the outputs hold the most recently popped entry (zero after reset)
  assign instr = out_valid ? w_head[31:0] : r_last_instr;
  assign err   = out_valid ? w_head[32]   : r_last_err;

  assign enc_cnt = r_enc_cnt;
  assign err_cnt = r_err_cnt;

  // FIFO storage; contents are only read while occupancy is non-zero, so no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_err, w_instr};
  end

  // Pointers, occupancy, held head value and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_instr <= 32'd0;
      r_last_err   <= 1'b0;
      r_enc_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + AW'(1);
        r_last_instr <= w_head[31:0];
        r_last_err   <= w_head[32];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && (r_enc_cnt != '1)) r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      if (w_push && w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Testbench for rv32i_instr_encoder: vector table, FIFO fill/drain and mid-stream reset.
// Expected words are hand-assembled constants carried through a scoreboard queue.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_rv32i_instr_encoder;

`ifdef ENCODER_RANGE_CHK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [9:0]  func;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [9:0]  func;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] enc_cnt;
  logic [15:0] err_cnt;

  logic [31:0] exp_instr;
  logic        exp_err;
  logic [32:0] sb [$];
  logic [32:0] sb_e;
  vec_t        vecs [16];
  int          errors = 0;
  int          checks = 0;

  rv32i_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .err(err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: compare the head on every pop, record the expectation on every accept
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: unexpected output 0x%08h", instr);
        end else begin
          sb_e = sb.pop_front();
          chk("sb_instr", instr, sb_e[31:0]);
          chk("sb_err", {31'd0, err}, {31'd0, sb_e[32]});
        end
      end
      if (in_valid && in_ready) sb.push_back({exp_err, exp_instr});
    end
  end

  task automatic drive(input vec_t v);
    op = v.op; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd; func = v.func; imm = v.imm;
    exp_instr = v.exp_instr;
    exp_err   = v.exp_err;
    in_valid  = 1'b1;
  endtask

  task automatic send(input vec_t v);
    bit acc = 1'b0;
    int n = 0;
    drive(v);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("sb_leftover", sb.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{7'h13, 5'd0, 5'd0, 5'd1,  10'h000, 32'd5,        32'h00500093, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{7'h33, 5'd1, 5'd2, 5'd3,  10'h000, 32'd0,        32'h002081B3, 1'b0}; // add x3,x1,x2
    vecs[2]  = '{7'h33, 5'd1, 5'd2, 5'd3,  10'h100, 32'd0,        32'h402081B3, 1'b0}; // sub
    vecs[3]  = '{7'h13, 5'd1, 5'd0, 5'd1,  10'h105, 32'd3,        32'h4030D093, 1'b0}; // srai x1,x1,3
    vecs[4]  = '{7'h23, 5'd1, 5'd2, 5'd9,  10'h002, 32'd8,        32'h0020A423, 1'b0}; // sw x2,8(x1), rd ignored
    vecs[5]  = '{7'h63, 5'd1, 5'd2, 5'd31, 10'h000, 32'd16,       32'h00208863, 1'b0}; // beq +16, rd ignored
    vecs[6]  = '{7'h6F, 5'd0, 5'd0, 5'd1,  10'h000, 32'd2048,     32'h001000EF, 1'b0}; // jal x1,+2048
    vecs[7]  = '{7'h37, 5'd0, 5'd0, 5'd5,  10'h000, 32'h12345000, 32'h123452B7, 1'b0}; // lui x5
    vecs[8]  = '{7'h7F, 5'd3, 5'd2, 5'd4,  10'h3FF, 32'd1,        32'h00000000, 1'b1}; // unknown op
    vecs[9]  = '{7'h63, 5'd1, 5'd2, 5'd0,  10'h000, 32'd3,        32'h00208163, RCHK}; // beq odd imm
    vecs[10] = '{7'h13, 5'd0, 5'd0, 5'd1,  10'h000, 32'h800,      32'h80000093, RCHK}; // addi 0x800
    vecs[11] = '{7'h03, 5'd2, 5'd0, 5'd5,  10'h002, 32'hFFFFFFFC, 32'hFFC12283, 1'b0}; // lw x5,-4(x2)
    vecs[12] = '{7'h63, 5'd1, 5'd2, 5'd0,  10'h001, 32'hFFFFFFF8, 32'hFE209CE3, 1'b0}; // bne -8
    vecs[13] = '{7'h17, 5'd0, 5'd0, 5'd1,  10'h000, 32'h1000,     32'h00001097, 1'b0}; // auipc x1
    vecs[14] = '{7'h67, 5'd1, 5'd0, 5'd0,  10'h000, 32'd0,        32'h00008067, 1'b0}; // jalr x0,0(x1)
    vecs[15] = '{7'h13, 5'd1, 5'd7, 5'd1,  10'h001, 32'd1,        32'h00109093, 1'b0}; // slli, rs2 ignored

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; rd = '0; func = '0; imm = '0;
    exp_instr = '0; exp_err = 1'b0;

    // Reset state
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // One-cycle latency and no combinational in->out path
    drive(vecs[0]);
    @(negedge clk);
    chk("lat_before_edge", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_instr", instr, 32'h00500093);
    drain();
    chk("hold_after_pop", instr, 32'h00500093);

    // Vector table streamed with the consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(vecs[i]);
    drain();
    chk("tbl_enc_cnt", {16'd0, enc_cnt}, 32'd16);
    chk("tbl_err_cnt", {16'd0, err_cnt}, RCHK ? 32'd3 : 32'd1);

    // Fill to DEPTH with consumer stalled, then release
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[i]);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(vecs[4]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_stall_enc_cnt", {16'd0, enc_cnt}, 32'd4);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vecs[4]);
    send(vecs[5]);
    drain();
    chk("full_enc_cnt", {16'd0, enc_cnt}, 32'd6);

    // Asynchronous reset with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[6 + i]);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_enc_cnt", {16'd0, enc_cnt}, 32'd0);
    chk("mid_rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    send(vecs[0]);
    drain();
    chk("post_rst_instr", instr, 32'h00500093);
    chk("post_rst_enc_cnt", {16'd0, enc_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Buffered RV32I instruction encoder. It is the inverse of the instruction decoder: it accepts decoded fields (op, rs1, rs2, rd, func, imm) and packs them into a 32-bit instruction word.
- Field conventions match the decoder exactly: func = {funct7, funct3}, and imm is the sign-extended, byte-offset immediate.
- Feeds a test-program generator / instruction memory loader. Uses valid/ready handshakes on both sides and an output FIFO.

Parameters:
- DEPTH, 4, output FIFO entries; power of 2, >= 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field set present.
- in_ready  out  1  encoder can accept; equals !full.
- op  in  7  opcode.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- rd  in  5  destination register.
- func  in  10  {funct7[9:3], funct3[2:0]}.
- imm  in  32  immediate, byte offset, sign-extended.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes the head entry.
- instr  out  32  encoded word at the FIFO head.
- err  out  1  error flag of the head entry.
- enc_cnt  out  CNT_W  accepted field sets, saturating.
- err_cnt  out  CNT_W  accepted sets with err=1, saturating.

Behaviour:
- Accept on in_valid & in_ready. Encoding is combinational from the inputs; {err, instr} is written into the FIFO in the same edge.
- Latency: accepted at edge N, visible at the head (out_valid=1) after edge N, i.e. one cycle. There is no combinational in->out path.
- Pop on out_valid & out_ready.
  - Simultaneous push and pop: allowed when not full; occupancy unchanged.
  - Full: in_ready=0; pop-to-make-room does not feed in_ready combinationally.
  - Empty: out_valid=0; instr and err hold the last popped/reset value (reset value 0).
- Pointers wrap modulo DEPTH. Occupancy is tracked with a (log2(DEPTH)+1)-bit count.
- Encoding (op[6:0] is always instr[6:0]):
  - R 0110011: {func[9:3], rs2, rs1, func[2:0], rd}.
  - I 0010011, funct3 = 001/101 (shifts): {func[9:3], imm[4:0], rs1, func[2:0], rd}.
  - I 0010011 other funct3, load 0000011, jalr 1100111: {imm[11:0], rs1, func[2:0], rd}.
  - S 0100011: {imm[11:5], rs2, rs1, func[2:0], imm[4:0]}.
  - B 1100011: {imm[12], imm[10:5], rs2, rs1, func[2:0], imm[4:1], imm[11]}.
  - U 0110111 / 0010111: {imm[31:12], rd}.
  - J 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd}.
  - Any other op: instr = 0, err = 1.
- Unused fields (rs2 for I type, rd for S/B, etc.) are ignored.
- Counters:
  - enc_cnt increments on every accept.
  - err_cnt increments on accepts whose err = 1.
  - Both saturate at all-ones; no wrap.
- Reset (async, any time, including mid-stream):
  - FIFO emptied, pointers 0, out_valid=0, instr=0, err=0, counters 0.
  - in_ready=1 from the first edge after deassertion.
  - Entries in flight are discarded.

Optional Feature:
- Macro ENCODER_RANGE_CHK_EN.
- Defined: err is also set when the immediate is not representable.
  - I/S: imm[31:11] not all equal.
  - Shift: imm[31:5] != 0.
  - B: imm[0]=1 or imm[31:12] not all equal.
  - J: imm[0]=1 or imm[31:20] not all equal.
  - U: imm[11:0] != 0.
  - The truncated encoding is still emitted.
- Undefined: err only for unknown opcodes; immediates are silently truncated.

Test Plan:
- ADDI x1,x0,5 (op 0010011, rd 1, func 0, imm 5) -> instr 0x00500093, err 0, out_valid 1 cycle after accept.
- ADD x3,x1,x2 -> 0x002081B3; SUB (func {0100000,000}) -> 0x402081B3; SRAI x1,x1,3 (func {0100000,101}, imm 3) -> 0x4030D093.
- SW x2,8(x1) -> 0x0020A423; BEQ x1,x2,+16 -> 0x00208863; JAL x1,+2048 -> 0x001000EF; LUI x5,0x12345000 -> 0x123452B7.
- DEPTH=4, out_ready=0, stream 6 valid sets -> in_ready drops after 4 accepts. Then out_ready=1 -> entries pop in order, no loss or duplication, enc_cnt=6 at end.
- op 1111111 -> instr 0, err 1, err_cnt+1. With ENCODER_RANGE_CHK_EN: BEQ imm=3 -> err 1; ADDI imm=0x800 -> err 1. Without the macro: both err 0.
- Assert rst_n low with 3 entries queued -> out_valid=0, counters 0 immediately; after release, a new ADDI encodes correctly.
